// File: rtl/bpi_req_arbiter.sv
// Fixed-priority owner arbiter for the BPI flash command port: auto-load beats user,
// with a post-release guard interval, an owner-only EXECUTE gate and a BUSY watchdog.
module bpi_req_arbiter #(
    parameter int unsigned GUARD   = 4,
    parameter logic [23:0] TMO_CYC = 24'd4000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AL_ENA,
    input  logic [22:0] AL_ADDR,
    input  logic [15:0] AL_DATA,
    input  logic [1:0]  AL_OP,
    input  logic        AL_EXECUTE,
    output logic        AL_GNT,
    output logic        AL_BUSY,
    input  logic        USR_ENA,
    input  logic [22:0] USR_ADDR,
    input  logic [15:0] USR_DATA,
    input  logic [1:0]  USR_OP,
    input  logic        USR_EXECUTE,
    output logic        USR_GNT,
    output logic        USR_BUSY,
    input  logic        BPI_BUSY,
    output logic [22:0] BPI_ADDR,
    output logic [15:0] BPI_DATA,
    output logic [1:0]  BPI_OP,
    output logic        BPI_EXECUTE,
    output logic        TMO,
    output logic [7:0]  DROP_CNT
);
    localparam int unsigned AW = 23;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 2;
    localparam int unsigned GW = 4;
    localparam int unsigned WW = 24;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, GNT_AL, GNT_USR, HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          al_gnt_q, al_gnt_d;
    logic          usr_gnt_q, usr_gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [OW-1:0] op_q, op_d;
    logic          exec_q, exec_d;
    logic          tmo_q, tmo_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          in_gnt;
    logic          wdog_exp;
    logic          al_ok, usr_ok, al_rej, usr_rej;
    logic [CW:0]   drop_sum;

    assign in_gnt   = (state_q == GNT_AL) || (state_q == GNT_USR);
    assign wdog_exp = in_gnt && BPI_BUSY && (wdog_q == TMO_CYC - 24'd1);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            guard_q   <= '0;
            wdog_q    <= '0;
            al_gnt_q  <= 1'b0;
            usr_gnt_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= '0;
            exec_q    <= 1'b0;
            tmo_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            wdog_q    <= wdog_d;
            al_gnt_q  <= al_gnt_d;
            usr_gnt_q <= usr_gnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            op_q      <= op_d;
            exec_q    <= exec_d;
            tmo_q     <= tmo_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state: owners release only once the BPI side is quiet, or on watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (AL_ENA)       state_d = GNT_AL;
                else if (USR_ENA) state_d = GNT_USR;
            end
            GNT_AL: begin
                if (wdog_exp || (!AL_ENA && !BPI_BUSY && !exec_q)) state_d = HOLDOFF;
            end
            GNT_USR: begin
                if (wdog_exp || (!USR_ENA && !BPI_BUSY && !exec_q)) state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (guard_q == GW'(GUARD - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant flags, muxed command, execute gate, counters
    always_comb begin
        guard_d  = '0;
        wdog_d   = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        tmo_d    = wdog_exp;
        al_gnt_d  = (state_d == GNT_AL);
        usr_gnt_d = (state_d == GNT_USR);

        if (state_q == HOLDOFF) guard_d = guard_q + GW'(1);
        if (in_gnt && BPI_BUSY && !wdog_exp) wdog_d = wdog_q + WW'(1);

        if (state_q == GNT_AL) begin
            addr_d = AL_ADDR;
            data_d = AL_DATA;
            op_d   = AL_OP;
        end else if (state_q == GNT_USR) begin
            addr_d = USR_ADDR;
            data_d = USR_DATA;
            op_d   = USR_OP;
        end

        al_ok    = AL_EXECUTE  && al_gnt_q  && !BPI_BUSY && !exec_q;
        usr_ok   = USR_EXECUTE && usr_gnt_q && !BPI_BUSY && !exec_q;
        al_rej   = AL_EXECUTE  && !al_ok;
        usr_rej  = USR_EXECUTE && !usr_ok;
        exec_d   = al_ok || usr_ok;
        drop_sum = {1'b0, drop_q} + (CW+1)'(al_rej) + (CW+1)'(usr_rej);
        drop_d   = drop_sum[CW] ? {CW{1'b1}} : drop_sum[CW-1:0];
    end

    assign AL_GNT      = al_gnt_q;
    assign USR_GNT     = usr_gnt_q;
    assign AL_BUSY     = !al_gnt_q  || BPI_BUSY || exec_q;
    assign USR_BUSY    = !usr_gnt_q || BPI_BUSY || exec_q;
    assign BPI_ADDR    = addr_q;
    assign BPI_DATA    = data_q;
    assign BPI_OP      = op_q;
    assign BPI_EXECUTE = exec_q;
    assign TMO         = tmo_q;
    assign DROP_CNT    = drop_q;

endmodule

// File: tb/tb_bpi_req_arbiter.sv
// Directed bench for bpi_req_arbiter (GUARD=4, TMO_CYC=16).
module tb_bpi_req_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        AL_ENA, AL_EXECUTE, USR_ENA, USR_EXECUTE, BPI_BUSY;
    logic [22:0] AL_ADDR, USR_ADDR;
    logic [15:0] AL_DATA, USR_DATA;
    logic [1:0]  AL_OP, USR_OP;
    logic        AL_GNT, AL_BUSY, USR_GNT, USR_BUSY, BPI_EXECUTE, TMO;
    logic [22:0] BPI_ADDR;
    logic [15:0] BPI_DATA;
    logic [1:0]  BPI_OP;
    logic [7:0]  DROP_CNT;

    int n_cmp = 0;
    int n_err = 0;

    bpi_req_arbiter #(.GUARD(4), .TMO_CYC(24'd16)) dut (
        .CLK(CLK), .RST(RST),
        .AL_ENA(AL_ENA), .AL_ADDR(AL_ADDR), .AL_DATA(AL_DATA), .AL_OP(AL_OP),
        .AL_EXECUTE(AL_EXECUTE), .AL_GNT(AL_GNT), .AL_BUSY(AL_BUSY),
        .USR_ENA(USR_ENA), .USR_ADDR(USR_ADDR), .USR_DATA(USR_DATA), .USR_OP(USR_OP),
        .USR_EXECUTE(USR_EXECUTE), .USR_GNT(USR_GNT), .USR_BUSY(USR_BUSY),
        .BPI_BUSY(BPI_BUSY), .BPI_ADDR(BPI_ADDR), .BPI_DATA(BPI_DATA), .BPI_OP(BPI_OP),
        .BPI_EXECUTE(BPI_EXECUTE), .TMO(TMO), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; AL_ENA = 0; AL_EXECUTE = 0; USR_ENA = 0; USR_EXECUTE = 0; BPI_BUSY = 0;
        AL_ADDR = '0; AL_DATA = '0; AL_OP = '0; USR_ADDR = '0; USR_DATA = '0; USR_OP = '0;
        step(); step();
        chk("rst_al_gnt", 32'(AL_GNT), 0);
        chk("rst_usr_gnt", 32'(USR_GNT), 0);
        chk("rst_al_busy", 32'(AL_BUSY), 1);
        chk("rst_usr_busy", 32'(USR_BUSY), 1);
        chk("rst_exec", 32'(BPI_EXECUTE), 0);
        chk("rst_tmo", 32'(TMO), 0);
        chk("rst_drop", 32'(DROP_CNT), 0);
        chk("rst_addr", 32'(BPI_ADDR), 0);
        RST = 1'b0;
        step();

        // 1: auto-load grant and forwarded execute
        AL_ENA = 1; step();
        chk("t1_al_gnt", 32'(AL_GNT), 1);
        chk("t1_al_busy", 32'(AL_BUSY), 0);
        AL_ADDR = 23'h7FC005; AL_DATA = 16'hA5C3; AL_OP = 2'd2; AL_EXECUTE = 1; step();
        chk("t1_exec", 32'(BPI_EXECUTE), 1);
        chk("t1_addr", 32'(BPI_ADDR), 32'h7FC005);
        chk("t1_data", 32'(BPI_DATA), 32'hA5C3);
        chk("t1_op", 32'(BPI_OP), 2);
        chk("t1_drop", 32'(DROP_CNT), 0);
        chk("t1_al_busy_exec", 32'(AL_BUSY), 1);
        AL_EXECUTE = 0; step();
        chk("t1_exec_pulse", 32'(BPI_EXECUTE), 0);
        AL_ENA = 0; step();
        chk("t1_release", 32'(AL_GNT), 0);
        repeat (4) step();

        // 2: simultaneous request, AL wins; guard interval before USR
        AL_ENA = 1; USR_ENA = 1; step();
        chk("t2_al_gnt", 32'(AL_GNT), 1);
        chk("t2_usr_gnt", 32'(USR_GNT), 0);
        chk("t2_usr_busy", 32'(USR_BUSY), 1);
        AL_ENA = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_guard_al", 32'(AL_GNT), 0);
            chk("t2_guard_usr", 32'(USR_GNT), 0);
        end
        step();
        chk("t2_usr_gnt_on", 32'(USR_GNT), 1);
        USR_ADDR = 23'h012345; USR_DATA = 16'h1234; USR_OP = 2'd1; USR_EXECUTE = 1; step();
        chk("t2_exec", 32'(BPI_EXECUTE), 1);
        chk("t2_addr", 32'(BPI_ADDR), 32'h012345);
        chk("t2_data", 32'(BPI_DATA), 32'h1234);
        chk("t2_op", 32'(BPI_OP), 1);
        USR_EXECUTE = 0; step();
        chk("t2_exec_pulse", 32'(BPI_EXECUTE), 0);

        // 3: rejected strobes and saturation
        AL_EXECUTE = 1; step();
        chk("t3_nonowner_exec", 32'(BPI_EXECUTE), 0);
        chk("t3_drop1", 32'(DROP_CNT), 1);
        AL_EXECUTE = 0; BPI_BUSY = 1; USR_EXECUTE = 1; step();
        chk("t3_busy_exec", 32'(BPI_EXECUTE), 0);
        chk("t3_drop2", 32'(DROP_CNT), 2);
        chk("t3_usr_busy", 32'(USR_BUSY), 1);
        AL_EXECUTE = 1; step();
        chk("t3_drop4", 32'(DROP_CNT), 4);
        BPI_BUSY = 0; USR_EXECUTE = 0;
        repeat (251) step();
        chk("t3_drop_ff", 32'(DROP_CNT), 32'hFF);
        repeat (49) step();
        chk("t3_drop_sat", 32'(DROP_CNT), 32'hFF);
        chk("t3_usr_still", 32'(USR_GNT), 1);
        AL_EXECUTE = 0; step();

        // 4: release while busy holds the grant
        USR_ENA = 0; BPI_BUSY = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold", 32'(USR_GNT), 1);
        end
        BPI_BUSY = 0; step();
        chk("t4_release", 32'(USR_GNT), 0);
        chk("t4_no_tmo", 32'(TMO), 0);
        repeat (4) step();

        // 5: watchdog expiry and re-grant
        AL_ENA = 1; step();
        chk("t5_gnt", 32'(AL_GNT), 1);
        BPI_BUSY = 1;
        repeat (15) step();
        chk("t5_tmo_early", 32'(TMO), 0);
        chk("t5_gnt_early", 32'(AL_GNT), 1);
        step();
        chk("t5_tmo", 32'(TMO), 1);
        chk("t5_gnt_drop", 32'(AL_GNT), 0);
        BPI_BUSY = 0; step();
        chk("t5_tmo_pulse", 32'(TMO), 0);
        repeat (3) step();
        chk("t5_guard", 32'(AL_GNT), 0);
        step();
        chk("t5_regrant", 32'(AL_GNT), 1);

        // 6: reset mid-grant with pending execute
        AL_EXECUTE = 1; RST = 1; step();
        chk("t6_gnt", 32'(AL_GNT), 0);
        chk("t6_exec", 32'(BPI_EXECUTE), 0);
        chk("t6_drop", 32'(DROP_CNT), 0);
        chk("t6_al_busy", 32'(AL_BUSY), 1);
        RST = 0; AL_EXECUTE = 0; AL_ENA = 0; step();
        chk("t6_idle", 32'(AL_GNT), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
